serial_alu_sequencer: RTL and testbench

Bit-serial execution controller that drives one single-bit ALU slice (A/B/CIN/OP/SET in, R/COUT out) LSB-first, one bit per clock. It latches full-width operands and an opcode, feeds the slice bit i at step i, carries COUT back into CIN, and assembles the WIDTH-bit result plus zero, carry and overflow flags. It serves as the low-area ALU path of the multicycle datapath. Set-less-than is handled with an extra step that feeds the computed sign back into the slice's SET input.

---
 rtl/serial_alu_sequencer.sv | 176 +++++++++++++++++
 tb/tb_serial_alu_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_sequencer.sv
// serial_alu_sequencer
//   Bit-serial controller for a single-bit ALU slice. Operands and opcode are
//   latched when start is accepted. Bits are then fed to the slice LSB-first,
//   one per clock, with COUT looped back into CIN. The controller assembles
//   the WIDTH-bit result and the zero/carry/overflow flags. Set-less-than runs
//   a subtract over all bits, then spends one extra step that feeds the
//   overflow-corrected sign into the slice's SET input at bit 0.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   start, op, a, b      request, opcode and operands (sampled while idle)
//   busy, done           busy from accept through the done cycle; done pulse
//   result, zero         assembled result and result==0, held until next start
//   carry_out, overflow  final carry / signed overflow of the sum path
//   slice_a/b/cin/op/set drive to the external slice
//   slice_r, slice_cout  combinational return from the slice
module serial_alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [3:0]       slice_op,
  output logic             slice_set,
  input  logic             slice_r,
  input  logic             slice_cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SETBIT,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       op_q;
  logic             carry_q;
  logic             sign_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             carry_out_q;
  logic             overflow_q;

  logic             is_sum;
  logic             is_slt;
  logic             last_bit;
  logic [WIDTH-1:0] result_shift_d;
  logic [WIDTH-1:0] result_set_d;

  assign is_sum   = (op_q[1:0] == 2'b00);
  assign is_slt   = (op_q[1:0] == 2'b11);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // The result fills from the MSB end, so after WIDTH shifts bit 0 lands at
  // result[0].
  assign result_shift_d = {slice_r, result_q[WIDTH-1:1]};
  assign result_set_d   = {{(WIDTH-1){1'b0}}, slice_r};

  // Slice drive is decoded from the registered state and latched operands.
  // This lets the slice's combinational R/COUT settle within the same cycle.
  always_comb begin
    slice_a   = 1'b0;
    slice_b   = 1'b0;
    slice_cin = 1'b0;
    slice_op  = 4'b0000;
    slice_set = 1'b0;
    case (state_q)
      S_RUN: begin
        slice_a   = a_q[cnt_q];
        slice_b   = b_q[cnt_q];
        slice_cin = carry_q;
        // SLT runs the subtract on the sum path; invert-B is kept.
        slice_op  = {op_q[3:2], (is_slt ? 2'b00 : op_q[1:0])};
      end
      S_SETBIT: begin
        slice_a   = a_q[0];
        slice_b   = b_q[0];
        slice_cin = 1'b1;
        slice_op  = op_q;
        slice_set = sign_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      carry_q     <= 1'b0;
      sign_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            cnt_q   <= '0;
            carry_q <= op[2];
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          carry_q  <= slice_cout;
          result_q <= result_shift_d;
          cnt_q    <= cnt_q + CW'(1);
          if (last_bit) begin
            // The true sign of the difference is the sum MSB corrected by
            // the signed-overflow term (carry into MSB XOR carry out).
            sign_q      <= slice_r ^ (carry_q ^ slice_cout);
            carry_out_q <= is_sum & slice_cout;
            overflow_q  <= is_sum & (carry_q ^ slice_cout);
            if (is_slt) begin
              state_q <= S_SETBIT;
            end else begin
              zero_q  <= (result_shift_d == '0);
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_SETBIT: begin
          result_q <= result_set_d;
          zero_q   <= ~slice_r;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
module tb_serial_alu_sequencer;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         carry_out;
  logic         overflow;
  logic         slice_a;
  logic         slice_b;
  logic         slice_cin;
  logic [3:0]   slice_op;
  logic         slice_set;
  logic         slice_r;
  logic         slice_cout;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] last_res;
  logic [2:0]   last_flags;

  serial_alu_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .zero       (zero),
    .carry_out  (carry_out),
    .overflow   (overflow),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_op   (slice_op),
    .slice_set  (slice_set),
    .slice_r    (slice_r),
    .slice_cout (slice_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the external one-bit ALU slice.
  logic slice_bb;
  always_comb begin
    slice_bb   = slice_b ^ slice_op[2];
    slice_cout = (slice_a & slice_bb) | (slice_a & slice_cin) | (slice_bb & slice_cin);
    case (slice_op[1:0])
      2'b00:   slice_r = slice_a ^ slice_bb ^ slice_cin;
      2'b01:   slice_r = slice_a & slice_bb;
      2'b10:   slice_r = slice_a | slice_bb;
      default: slice_r = slice_set;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Carry entering bit i of x + y + c0.
  function automatic logic cin_at(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic c0, input int i);
    logic [63:0] m;
    logic [63:0] s;
    m = (64'd1 << i) - 64'd1;
    s = (64'(x) & m) + (64'(y) & m) + 64'(c0);
    return s[i];
  endfunction

  // Reference: the arithmetic result of an operation.
  task automatic ref_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [3:0] top,
                        output logic [W-1:0] res, output logic c, output logic v,
                        output logic neg);
    logic [W-1:0] bsel;
    logic [W:0]   full;
    longint       sa;
    longint       sb;
    longint       sv;
    bsel = top[2] ? ~tb_ : tb_;
    full = {1'b0, ta} + {1'b0, bsel} + {{W{1'b0}}, top[2]};
    sa   = longint'($signed(ta));
    sb   = longint'($signed(tb_));
    sv   = top[2] ? (sa - sb) : (sa + sb);
    neg  = (sv < 0);
    c    = 1'b0;
    v    = 1'b0;
    case (top[1:0])
      2'b00: begin
        res = full[W-1:0];
        c   = full[W];
        v   = (ta[W-1] == bsel[W-1]) && (full[W-1] != ta[W-1]);
      end
      2'b01:   res = ta & bsel;
      2'b10:   res = ta | bsel;
      default: res = {{(W-1){1'b0}}, neg};
    endcase
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [3:0] top,
                       input bit poke_run, input bit poke_done);
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         neg;
    logic [W-1:0] bsel;
    logic [3:0]   run_op;
    ref_op(ta, tb_, top, res, c, v, neg);
    bsel   = top[2] ? ~tb_ : tb_;
    run_op = (top[1:0] == 2'b11) ? {top[3:2], 2'b00} : top;

    @(negedge clk);
    chk("idle_hold", {busy, done, result, zero, carry_out, overflow,
                      slice_a, slice_b, slice_cin, slice_set, slice_op},
        {2'b00, last_res, last_flags, 8'h00});
    a = ta; b = tb_; op = top; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));

    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("run_bit", {busy, done, slice_a, slice_b, slice_cin, slice_set, slice_op},
          {2'b10, ta[i], tb_[i], cin_at(ta, bsel, top[2], i), 1'b0, run_op});
      if (poke_run && i == 5) start = 1'b1;
      if (i == 6) start = 1'b0;
    end

    if (top[1:0] == 2'b11) begin
      @(negedge clk);
      chk("setbit", {busy, done, slice_a, slice_b, slice_cin, slice_set, slice_op},
          {2'b10, ta[0], tb_[0], 1'b1, neg, top});
    end

    @(negedge clk);
    chk("done", {busy, done, result, zero, carry_out, overflow,
                 slice_a, slice_b, slice_cin, slice_set, slice_op},
        {2'b11, res, (res == '0), c, v, 8'h00});
    $display("op=%b a=%h b=%h result=%h zero=%b c=%b v=%b exp=%h",
             top, ta, tb_, result, zero, carry_out, overflow, res);
    last_res   = res;
    last_flags = {(res == '0), c, v};
    if (poke_done) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic reset_mid_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [3:0] top);
    @(negedge clk);
    a = ta; b = tb_; op = top; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i <= 10; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid", {busy, done, result, zero, carry_out, overflow,
                      slice_a, slice_b, slice_cin, slice_set, slice_op}, 64'h0);
    reset = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      chk("no_done", {busy, done}, 64'h0);
    end
    $display("reset during op=%b a=%h b=%h abandoned", top, ta, tb_);
    last_res   = '0;
    last_flags = 3'b000;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    reset = 1'b1; start = 1'b0; op = 4'h0; a = '0; b = '0;
    last_res = '0; last_flags = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", {busy, done, result, zero, carry_out, overflow,
                  slice_a, slice_b, slice_cin, slice_set, slice_op}, 64'h0);
    reset = 1'b0;

    do_op(32'd5, 32'd3, 4'b0000, 1'b0, 1'b0);
    do_op(32'd3, 32'd5, 4'b0100, 1'b0, 1'b0);
    do_op(32'h1234, 32'h1234, 4'b0100, 1'b0, 1'b0);
    do_op(32'h7FFFFFFF, 32'd1, 4'b0000, 1'b0, 1'b0);
    do_op(32'hF0F0F0F0, 32'hFF00FF00, 4'b0001, 1'b0, 1'b0);
    do_op(32'hF0F0F0F0, 32'hFF00FF00, 4'b0010, 1'b0, 1'b0);
    do_op(32'hFFFFFFFF, 32'd1, 4'b0111, 1'b0, 1'b0);
    do_op(32'h80000000, 32'd1, 4'b0111, 1'b0, 1'b0);
    do_op(32'd1, 32'h80000000, 4'b0111, 1'b0, 1'b0);
    do_op(32'h0000FFFF, 32'h00000001, 4'b0000, 1'b1, 1'b1);
    do_op(32'h80000000, 32'h80000000, 4'b0000, 1'b1, 1'b0);
    do_op(32'd7, 32'd7, 4'b0111, 1'b0, 1'b1);

    reset_mid_op(32'h12345678, 32'h9ABCDEF0, 4'b0000);
    do_op(32'd100, 32'd23, 4'b0000, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 8 == 1) ra = 32'h80000000;
      if (n % 8 == 2) rb = 32'h7FFFFFFF;
      if (n % 8 == 3) rb = ra;
      do_op(ra, rb, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
